// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int data_w, input int depth,
                                input int af_level, input int ae_level);
    return (data_w >= 1) && is_pow2(depth) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  // Contents survive reset; the pointers alone define what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered output.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       r_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ptr_width(DEPTH)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  if (!cfg_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_cfg_check
    $error("fifo_sync_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  // Handshake: w_en and r_en are requests judged against the registered flags;
  // a write is accepted at the rising edge iff w_en & !full, a read iff
  // r_en & !empty. Rejected requests leave pointers, memory and data_out alone.
  logic [PTR_W-1:0]  w_ptr;
  logic [PTR_W-1:0]  r_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_data;

  assign empty  = (w_ptr == r_ptr);
  assign full   = (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]) &&
                  (w_ptr[PTR_W-1] != r_ptr[PTR_W-1]);
  assign count  = w_ptr - r_ptr;
  assign almost_full  = (count >= PTR_W'(AF_LEVEL));
  assign almost_empty = (count <= PTR_W'(AE_LEVEL));

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)        w_ptr     <= w_ptr + PTR_W'(1);
      if (rd_acc)        r_ptr     <= r_ptr + PTR_W'(1);
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (w_ptr[ADDR_W-1:0]),
    .w_data (data_in),
    .r_addr (r_ptr[ADDR_W-1:0]),
    .r_data (rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head word is shown as soon as it exists; r_en merely retires it.
  assign data_out = empty ? '0 : rd_data;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= rd_data;
    end
  end
`endif

endmodule
